stepgen_bank: RTL and testbench



---
 rtl/remora_pkg.sv | 16 +
 rtl/stepgen_channel.sv | 130 +++++++++++++
 rtl/stepgen_bank.sv | 41 ++++
 tb/tb_stepgen_bank.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/remora_pkg.sv
// Shared constants and types for the remora step/dir generator bank.
package remora_pkg;

    localparam int   JOINT_W = 32;
    localparam logic DIR_POS = 1'b1;

    typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} sg_state_t;

    // Counter width able to hold 0..max(a,b)-1, never narrower than one bit.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/stepgen_channel.sv
// One step/dir channel: command shadow, phase accumulator, one-deep request latch,
// pulse-shaping FSM and signed step-count feedback.
module stepgen_channel
    import remora_pkg::*;
#(
    parameter int PULSE_LEN = 16,
    parameter int DIR_SETUP = 16,
    parameter int CNT_W     = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    input  logic [JOINT_W-1:0] freq_cmd,
    input  logic               run,
    output logic [JOINT_W-1:0] feedback,
    output logic               step,
    output logic               dir,
    output logic               overrun
);

    logic [JOINT_W-1:0] shadow, acc, mag, fb_nxt;
    logic [JOINT_W:0]   sum;
    logic               carry, req_dir, pending, pend_dir, pend_eff;
    logic               consume, take, step_nxt, dir_nxt;
    sg_state_t          state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;

    // Two's-complement negate of -2^31 wraps to 2^31, which is the correct magnitude.
    assign mag      = shadow[JOINT_W-1] ? (~shadow + JOINT_W'(1)) : shadow;
    assign sum      = {1'b0, acc} + {1'b0, mag};
    assign carry    = run & sum[JOINT_W];
    assign req_dir  = ~shadow[JOINT_W-1];
    assign pend_eff = pending & run;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // NOTE: every signal written here gets a default first, otherwise a latch is inferred.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        take      = 1'b0;
        case (state)
            IDLE:  take = 1'b1;
            SETUP: begin
                if (!pend_eff) begin
                    state_nxt = IDLE;
                end else if (cnt == CNT_W'(DIR_SETUP - 1)) begin
                    state_nxt = HIGH;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            HIGH: begin
                if (cnt == CNT_W'(PULSE_LEN - 1)) begin
                    state_nxt = LOW;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            LOW: begin
                if (cnt == CNT_W'(PULSE_LEN - 1)) begin
                    state_nxt = IDLE;
                    take      = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
        endcase
        // The last LOW cycle doubles as an IDLE cycle so back-to-back steps sustain 2*PULSE_LEN.
        if (take && pend_eff) begin
            cnt_nxt   = '0;
            state_nxt = (pend_dir == dir) ? HIGH : SETUP;
        end
    end

    always_comb begin
        consume  = (state_nxt == HIGH) && (state != HIGH);
        step_nxt = (state_nxt == HIGH);
        dir_nxt  = ((state_nxt == SETUP) && (state != SETUP)) ? pend_dir : dir;
        fb_nxt   = feedback;
        if (consume)
            fb_nxt = feedback + ((dir == DIR_POS) ? JOINT_W'(1) : {JOINT_W{1'b1}});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow   <= '0;
            acc      <= '0;
            pending  <= 1'b0;
            pend_dir <= 1'b0;
            overrun  <= 1'b0;
            feedback <= '0;
            step     <= 1'b0;
            dir      <= 1'b0;
        end else begin
            if (cmd_valid)
                shadow <= freq_cmd;
            if (run)
                acc <= sum[JOINT_W-1:0];
            // A carry landing on the consume cycle replaces the consumed request.
            if (!run) begin
                pending <= 1'b0;
            end else if (carry) begin
                if (pending && !consume) begin
                    overrun <= 1'b1;
                end else begin
                    pending  <= 1'b1;
                    pend_dir <= req_dir;
                end
            end else if (consume) begin
                pending <= 1'b0;
            end
            feedback <= fb_nxt;
            step     <= step_nxt;
            dir      <= dir_nxt;
        end
    end

endmodule

// File: rtl/stepgen_bank.sv
// Bank of CHANNELS step/dir generators sharing one command strobe and a global fault stop.
module stepgen_bank
    import remora_pkg::*;
#(
    parameter int CHANNELS  = 5,
    parameter int PULSE_LEN = 16,
    parameter int DIR_SETUP = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    input  logic [CHANNELS*JOINT_W-1:0]   freq_cmd,
    input  logic [CHANNELS-1:0]           enable,
    input  logic                          fault,
    output logic [CHANNELS*JOINT_W-1:0]   feedback,
    output logic [CHANNELS-1:0]           step,
    output logic [CHANNELS-1:0]           dir,
    output logic [CHANNELS-1:0]           overrun
);

    localparam int CNT_W = cnt_width(PULSE_LEN, DIR_SETUP);

    for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
        stepgen_channel #(
            .PULSE_LEN (PULSE_LEN),
            .DIR_SETUP (DIR_SETUP),
            .CNT_W     (CNT_W)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .cmd_valid (cmd_valid),
            .freq_cmd  (freq_cmd[n*JOINT_W +: JOINT_W]),
            .run       (enable[n] & ~fault),
            .feedback  (feedback[n*JOINT_W +: JOINT_W]),
            .step      (step[n]),
            .dir       (dir[n]),
            .overrun   (overrun[n])
        );
    end

endmodule

// File: tb/tb_stepgen_bank.sv
// Scoreboard bench for stepgen_bank: expected step/dir edges are queued per channel with
// hand-computed cycle numbers; a negedge monitor pops and compares each edge the DUT shows.
module tb_stepgen_bank;

    localparam int CH = 2;
    localparam int PL = 4;
    localparam int DS = 8;

    logic            clk       = 1'b0;
    logic            rst       = 1'b1;
    logic            cmd_valid = 1'b0;
    logic            fault     = 1'b0;
    logic [CH*32-1:0] freq_cmd = '0;
    logic [CH-1:0]   enable    = '1;
    logic [CH*32-1:0] feedback;
    logic [CH-1:0]   step, dir, overrun;

    stepgen_bank #(.CHANNELS(CH), .PULSE_LEN(PL), .DIR_SETUP(DS)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .freq_cmd  (freq_cmd),
        .enable    (enable),
        .fault     (fault),
        .feedback  (feedback),
        .step      (step),
        .dir       (dir),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        is_step;
        logic [31:0] at;
        logic        d;
        logic [31:0] fb;
    } ev_t;

    ev_t           q0[$];
    ev_t           q1[$];
    bit            mon_en = 1'b0;
    logic [CH-1:0] prev_step = '0;
    logic [CH-1:0] prev_dir  = '0;
    int            rise_at[CH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] fb_of(input int c);
        return feedback[c*32 +: 32];
    endfunction

    task automatic expect_ev(input int c, input bit is_step, input int at, input logic d,
                             input logic [31:0] fb);
        ev_t e;
        e.is_step = is_step;
        e.at      = 32'(at);
        e.d       = d;
        e.fb      = fb;
        if (c == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic on_event(input int c, input bit is_step);
        ev_t         e;
        bit          have;
        logic [31:0] fb;
        have = 1'b0;
        fb   = fb_of(c);
        if (c == 0 && q0.size() > 0) begin
            e = q0.pop_front();
            have = 1'b1;
        end else if (c == 1 && q1.size() > 0) begin
            e = q1.pop_front();
            have = 1'b1;
        end
        checks++;
        if (!have) begin
            errors++;
            $display("FAIL ch%0d unexpected %s edge at cycle %0d (dir=%0b fb=%0h)",
                     c, is_step ? "step" : "dir", cyc, dir[c], fb);
        end else if (e.is_step != is_step || e.at != 32'(cyc) || e.d !== dir[c] || e.fb !== fb) begin
            errors++;
            $display("FAIL ch%0d edge: got %s cyc=%0d dir=%0b fb=%0h, expected %s cyc=%0d dir=%0b fb=%0h",
                     c, is_step ? "step" : "dir", cyc, dir[c], fb,
                     e.is_step ? "step" : "dir", e.at, e.d, e.fb);
        end
    endtask

    // Monitor: every step rise and dir change is matched against the channel's queue.
    always @(negedge clk) begin
        for (int c = 0; c < CH; c++) begin
            if (mon_en) begin
                if (step[c] && !prev_step[c])
                    on_event(c, 1'b1);
                if (!step[c] && prev_step[c])
                    check($sformatf("ch%0d high width", c), 32'(cyc - rise_at[c]), 32'(PL));
                if (dir[c] !== prev_dir[c])
                    on_event(c, 1'b0);
            end
            if (step[c] && !prev_step[c])
                rise_at[c] = cyc;
        end
        prev_step = step;
        prev_dir  = dir;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) tick();
    endtask

    task automatic load(input logic [31:0] c1, input logic [31:0] c0);
        freq_cmd  = {c1, c0};
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic assert_rst();
        mon_en    = 1'b0;
        rst       = 1'b1;
        fault     = 1'b0;
        cmd_valid = 1'b0;
        tick();
    endtask

    task automatic release_rst();
        rst = 1'b0;
        tick();
        mon_en = 1'b1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, " step"},    32'(step),    32'h0);
        check({tag, " dir"},     32'(dir),     32'h0);
        check({tag, " overrun"}, 32'(overrun), 32'h0);
        check({tag, " fb0"},     fb_of(0),     32'h0);
        check({tag, " fb1"},     fb_of(1),     32'h0);
    endtask

    initial begin
        int t0;

        tick(2);
        check_zero("reset");
        release_rst();

        // Constant rate: carry every 16 cycles, first step delayed by the dir setup.
        t0 = cyc;
        expect_ev(0, 1'b0, t0 + 18, 1'b1, 32'd0);
        expect_ev(0, 1'b1, t0 + 26, 1'b1, 32'd1);
        for (int n = 2; n <= 10; n++)
            expect_ev(0, 1'b1, t0 + 34 + 16 * (n - 2), 1'b1, 32'(n));
        load(32'h0, 32'h1000_0000);
        wait_until(t0 + 170);
        check("const q0 drained", 32'(q0.size()), 32'd0);
        check("const fb0", fb_of(0), 32'd10);
        check("const overrun", 32'(overrun), 32'h0);

        // Reversal: next carry at t0+176 carries req_dir = 0.
        expect_ev(0, 1'b0, t0 + 178, 1'b0, 32'd10);
        expect_ev(0, 1'b1, t0 + 186, 1'b0, 32'd9);
        expect_ev(0, 1'b1, t0 + 194, 1'b0, 32'd8);
        expect_ev(0, 1'b1, t0 + 210, 1'b0, 32'd7);
        load(32'h0, 32'hF000_0000);
        wait_until(t0 + 218);
        check("rev q0 drained", 32'(q0.size()), 32'd0);
        check("rev fb0", fb_of(0), 32'd7);

        // Overrun: -2^31 carries every 2 cycles, steps limited to one per 8 cycles.
        assert_rst();
        release_rst();
        t0 = cyc;
        for (int n = 0; n < 6; n++)
            expect_ev(0, 1'b1, t0 + 4 + 8 * n, 1'b0, 32'(-(n + 1)));
        load(32'h0, 32'h8000_0000);
        wait_until(t0 + 45);
        check("ovr q0 drained", 32'(q0.size()), 32'd0);
        check("ovr q1 drained", 32'(q1.size()), 32'd0);
        check("ovr overrun", 32'(overrun), 32'h1);
        check("ovr fb0", fb_of(0), 32'hFFFF_FFFA);
        check("ovr step high", 32'(step), 32'h1);
        assert_rst();
        check_zero("rst mid-pulse A");
        release_rst();

        // Fault in the second HIGH cycle of the second pulse.
        t0 = cyc;
        expect_ev(0, 1'b0, t0 + 18, 1'b1, 32'd0);
        expect_ev(0, 1'b1, t0 + 26, 1'b1, 32'd1);
        expect_ev(0, 1'b1, t0 + 34, 1'b1, 32'd2);
        load(32'h0, 32'h1000_0000);
        wait_until(t0 + 35);
        fault = 1'b1;
        wait_until(t0 + 60);
        check("fault q0 drained", 32'(q0.size()), 32'd0);
        check("fault fb0 held", fb_of(0), 32'd2);
        wait_until(t0 + 80);
        fault = 1'b0;
        expect_ev(0, 1'b1, t0 + 95, 1'b1, 32'd3);
        expect_ev(0, 1'b1, t0 + 111, 1'b1, 32'd4);
        wait_until(t0 + 112);
        check("resume q0 drained", 32'(q0.size()), 32'd0);
        check("resume fb0", fb_of(0), 32'd4);
        check("resume dir", 32'(dir), 32'h1);
        assert_rst();
        check_zero("rst mid-pulse B");
        release_rst();

        // Atomic load: unstrobed change ignored, strobe switches both channels at once.
        t0 = cyc;
        expect_ev(0, 1'b0, t0 + 18,  1'b1, 32'd0);
        expect_ev(0, 1'b1, t0 + 26,  1'b1, 32'd1);
        expect_ev(0, 1'b1, t0 + 34,  1'b1, 32'd2);
        expect_ev(0, 1'b1, t0 + 50,  1'b1, 32'd3);
        expect_ev(0, 1'b1, t0 + 66,  1'b1, 32'd4);
        expect_ev(0, 1'b1, t0 + 92,  1'b1, 32'd5);
        expect_ev(0, 1'b1, t0 + 124, 1'b1, 32'd6);
        expect_ev(1, 1'b0, t0 + 34,  1'b1, 32'd0);
        expect_ev(1, 1'b1, t0 + 42,  1'b1, 32'd1);
        expect_ev(1, 1'b1, t0 + 66,  1'b1, 32'd2);
        expect_ev(1, 1'b1, t0 + 85,  1'b1, 32'd3);
        expect_ev(1, 1'b1, t0 + 101, 1'b1, 32'd4);
        expect_ev(1, 1'b1, t0 + 117, 1'b1, 32'd5);
        load(32'h0800_0000, 32'h1000_0000);
        wait_until(t0 + 40);
        freq_cmd = {32'h4000_0000, 32'h4000_0000};
        wait_until(t0 + 70);
        load(32'h1000_0000, 32'h0800_0000);
        wait_until(t0 + 128);
        check("atomic q0 drained", 32'(q0.size()), 32'd0);
        check("atomic q1 drained", 32'(q1.size()), 32'd0);
        check("atomic fb0", fb_of(0), 32'd6);
        check("atomic fb1", fb_of(1), 32'd5);
        check("atomic overrun", 32'(overrun), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
